// File: rtl/game_state_ctrl_if.sv
// Game flow bus between the state controller and its environment.
// The controller uses the slave side; the start overlay / game logic drives master.
interface game_state_ctrl_if #(
    parameter int TIME_W = 16
);
    logic              game_start;
    logic [1:0]        char_class;
    logic              player_dead;
    logic              boss_dead;
    logic              vsync;
    logic [1:0]        game_active;
    logic              game_reset;
    logic              game_won;
    logic [TIME_W-1:0] play_frames;

    modport master (
        output game_start,
        output char_class,
        output player_dead,
        output boss_dead,
        output vsync,
        input  game_active,
        input  game_reset,
        input  game_won,
        input  play_frames
    );

    modport slave (
        input  game_start,
        input  char_class,
        input  player_dead,
        input  boss_dead,
        input  vsync,
        output game_active,
        output game_reset,
        output game_won,
        output play_frames
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Top-level game flow FSM: MENU -> PLAY -> END (frame delay) -> OVER -> MENU.
// vsync is used only as a frame tick; every output is registered.
module game_state_ctrl #(
    parameter int END_DELAY_FRAMES = 60,
    parameter int TIME_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    game_state_ctrl_if.slave gs
);
    localparam logic [1:0] S_MENU = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_END  = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    localparam logic [1:0] ACT_MENU = 2'd0;
    localparam logic [1:0] ACT_PLAY = 2'd1;
    localparam logic [1:0] ACT_OVER = 2'd2;

    localparam int CNT_W =
        (END_DELAY_FRAMES > 1) ? $clog2(END_DELAY_FRAMES) : 1;
    localparam logic [CNT_W-1:0] END_LAST =
        CNT_W'(END_DELAY_FRAMES - 1);
    localparam logic [TIME_W-1:0] TIME_MAX = '1;

    logic [1:0]        r_state;
    logic              r_vsync_q;
    logic [CNT_W-1:0]  r_end_cnt;
    logic [1:0]        r_game_active;
    logic              r_game_reset;
    logic              r_game_won;
    logic [TIME_W-1:0] r_play_frames;

    logic              w_frame_tick;
    logic              w_start_ok;
    logic              w_loss;
    logic              w_win;
    logic              w_end_done;
    logic              w_in_menu;
    logic              w_in_play;
    logic              w_in_end;
    logic              w_enter_end;
    logic [1:0]        w_next_state;
    logic [1:0]        w_next_active;

    assign w_frame_tick = gs.vsync & ~r_vsync_q;
    assign w_start_ok   = gs.game_start & (gs.char_class != 2'd0);

    assign w_in_menu = (r_state == S_MENU);
    assign w_in_play = (r_state == S_PLAY);
    assign w_in_end  = (r_state == S_END);

    // Player death wins over a simultaneous boss kill: a tie is a loss.
    assign w_loss = gs.player_dead;
    assign w_win  = gs.boss_dead & ~gs.player_dead;

    assign w_enter_end = w_in_play & (w_loss | w_win);
    assign w_end_done  = w_in_end & w_frame_tick &
                         (r_end_cnt == END_LAST);

    // Next-state selection for the round flow.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_MENU: begin
                if (w_start_ok) w_next_state = S_PLAY;
            end
            S_PLAY: begin
                if (w_loss | w_win) w_next_state = S_END;
            end
            S_END: begin
                if (w_end_done) w_next_state = S_OVER;
            end
            S_OVER: begin
                if (gs.game_start) w_next_state = S_MENU;
            end
            default: w_next_state = S_MENU;
        endcase
    end

    // Externally visible phase code; END reports as PLAY.
    always_comb begin
        w_next_active = ACT_PLAY;
        case (w_next_state)
            S_MENU:  w_next_active = ACT_MENU;
            S_OVER:  w_next_active = ACT_OVER;
            default: w_next_active = ACT_PLAY;
        endcase
    end

    // State register and the registered phase code that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_MENU;
            r_game_active <= ACT_MENU;
        end else begin
            r_state       <= w_next_state;
            r_game_active <= w_next_active;
        end
    end

    // Delayed vsync copy for rising-edge frame tick detection.
    always_ff @(posedge clk) begin
        if (rst) r_vsync_q <= 1'b0;
        else     r_vsync_q <= gs.vsync;
    end

    // Frames spent in END; cleared on entry, advanced per frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_end_cnt <= '0;
        end else if (w_enter_end) begin
            r_end_cnt <= '0;
        end else if (w_in_end & w_frame_tick & ~w_end_done) begin
            r_end_cnt <= r_end_cnt + 1'b1;
        end
    end

    // Round time: cleared on a new round, saturating count in PLAY only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_play_frames <= '0;
        end else if (w_in_menu & w_start_ok) begin
            r_play_frames <= '0;
        end else if (w_in_play & w_frame_tick &
                     (r_play_frames != TIME_MAX)) begin
            r_play_frames <= r_play_frames + 1'b1;
        end
    end

    // Result flag: set by a clean boss kill, cleared on loss or new round.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_game_won <= 1'b0;
        end else if (w_in_menu & w_start_ok) begin
            r_game_won <= 1'b0;
        end else if (w_in_play & w_loss) begin
            r_game_won <= 1'b0;
        end else if (w_in_play & w_win) begin
            r_game_won <= 1'b1;
        end
    end

    // One-cycle entity reinit pulse, only on the MENU to PLAY step.
    always_ff @(posedge clk) begin
        if (rst) r_game_reset <= 1'b0;
        else     r_game_reset <= w_in_menu & w_start_ok;
    end

    assign gs.game_active = r_game_active;
    assign gs.game_reset  = r_game_reset;
    assign gs.game_won    = r_game_won;
    assign gs.play_frames = r_play_frames;
endmodule
